// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: PC intake, instruction-memory request/response, decode output.
// Latency: none, wires only.
// Backpressure: carries pc_ready, mem_req_ready and instr_ready handshakes.
interface instr_fetch_queue_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);
    // Upstream PC handshake
    logic                     pc_valid;
    logic [ADDR_W-1:0]        pc_in;
    logic                     pc_ready;
    // Instruction memory request / in-order response
    logic                     mem_req_valid;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_req_ready;
    logic                     mem_rsp_valid;
    logic [INSTR_W-1:0]       mem_rsp_data;
    // Branch redirect
    logic                     flush;
    // Decode-side output
    logic                     instr_valid;
    logic [INSTR_W-1:0]       instr_data;
    logic [ADDR_W-1:0]        instr_pc;
    logic                     instr_ready;
    logic [$clog2(DEPTH):0]   occupancy;

    // The fetch queue itself
    modport master (
        input  pc_valid, pc_in, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               flush, instr_ready,
        output pc_ready, mem_req_valid, mem_addr, instr_valid, instr_data,
               instr_pc, occupancy
    );

    // Surrounding PC source, instruction memory and decoder
    modport slave (
        output pc_valid, pc_in, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               flush, instr_ready,
        input  pc_ready, mem_req_valid, mem_addr, instr_valid, instr_data,
               instr_pc, occupancy
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch queue: issues PC reads, pairs responses with PCs, buffers for decode.
// Latency: memory response in cycle N is visible on instr_valid in cycle N+1.
// Backpressure: pc_ready drops once queued + in-flight + discard-pending entries reach DEPTH.
module instr_fetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_queue_if.master  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] ONE = PW'(1);

    // Pointers carry one wrap bit above the ring index
    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    // Responses still owed by memory for fetches that a flush already threw away
    logic [PW-1:0] discard_cnt;

    logic [PW-1:0] occ;
    logic [PW-1:0] outstanding;
    logic [PW:0]   used;
    logic          credit_ok;
    logic          accept;
    logic          pop;
    logic          rsp_live;
    logic          fill_write;

    // Payload ring, deliberately not reset
    logic [ADDR_W-1:0]  pc_ram   [DEPTH];
    logic [INSTR_W-1:0] data_ram [DEPTH];

    // Occupancy, credit and handshake qualifiers
    always_comb begin
        occ         = alloc_ptr - head_ptr;
        outstanding = alloc_ptr - fill_ptr;
        used        = {1'b0, occ} + {1'b0, discard_cnt};
        credit_ok   = used < (PW+1)'(DEPTH);
        // A response counts as expected if it either retires a discard or fills an entry
        rsp_live    = bus.mem_rsp_valid & ((discard_cnt != '0) | (outstanding != '0));
        fill_write  = bus.mem_rsp_valid & ~bus.flush & ~reset
                    & (discard_cnt == '0) & (outstanding != '0);
    end

    assign bus.mem_req_valid = bus.pc_valid & credit_ok & ~bus.flush & ~reset;
    assign bus.mem_addr      = bus.pc_in;
    assign bus.pc_ready      = bus.mem_req_ready & credit_ok & ~bus.flush & ~reset;
    assign accept            = bus.pc_valid & bus.pc_ready;

    // instr_valid comes from registered pointers only, never straight from mem_rsp
    assign bus.instr_valid   = (head_ptr != fill_ptr) & ~bus.flush & ~reset;
    assign bus.instr_data    = data_ram[head_ptr[IW-1:0]];
    assign bus.instr_pc      = pc_ram[head_ptr[IW-1:0]];
    assign bus.occupancy     = occ;
    assign pop               = bus.instr_valid & bus.instr_ready;

    // Pointer and discard bookkeeping; flush collapses the ring onto alloc_ptr
    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            head_ptr    <= '0;
            discard_cnt <= '0;
        end else if (bus.flush) begin
            head_ptr    <= alloc_ptr;
            fill_ptr    <= alloc_ptr;
            // Every unfilled fetch becomes a discard, less one if its response lands right now
            discard_cnt <= discard_cnt + outstanding - {{(PW-1){1'b0}}, rsp_live};
        end else begin
            if (accept) begin
                alloc_ptr <= alloc_ptr + ONE;
            end
            if (pop) begin
                head_ptr <= head_ptr + ONE;
            end
            if (bus.mem_rsp_valid && discard_cnt != '0) begin
                discard_cnt <= discard_cnt - ONE;
            end
            if (fill_write) begin
                fill_ptr <= fill_ptr + ONE;
            end
        end
    end

    // Payload writes: PC at request time, instruction word at response time
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_ram[alloc_ptr[IW-1:0]] <= bus.pc_in;
        end
        if (fill_write) begin
            data_ram[fill_ptr[IW-1:0]] <= bus.mem_rsp_data;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a latency-programmable memory model and scoreboard.
// Latency: memory answers lat cycles after each accepted request.
// Backpressure: decode readiness and memory response timing are driven per scenario.
module tb_instr_fetch_queue;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus();

    instr_fetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct { int due; logic [7:0] addr; } mreq_t;
    mreq_t mq[$];
    int    lat      = 1;
    bit    mem_auto = 1'b1;
    logic  auto_v   = 1'b0;
    logic [15:0] auto_d = '0;
    logic  man_v    = 1'b0;
    logic [15:0] man_d  = '0;

    assign bus.mem_rsp_valid = mem_auto ? auto_v : man_v;
    assign bus.mem_rsp_data  = mem_auto ? auto_d : man_d;

    // Memory: record accepted reads, return {A5, addr} lat cycles later, in order
    always @(posedge clk) begin
        bit          acc;
        logic [7:0]  a;
        acc = bus.mem_req_valid && bus.mem_req_ready;
        a   = bus.mem_addr;
        if (auto_v && mq.size() != 0) void'(mq.pop_front());
        if (reset === 1'b1) mq.delete();
        else if (mem_auto && acc) mq.push_back('{cyc + lat, a});
        cyc++;
        #1;
        auto_v = 1'b0;
        auto_d = '0;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            auto_v = 1'b1;
            auto_d = {8'hA5, mq[0].addr};
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [7:0] pc; logic [15:0] data; } exp_t;
    exp_t exp_q[$];
    int   pop_cyc[$];

    // Push on accept, pop/compare on each decode handshake; flush/reset drop everything
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 || bus.flush === 1'b1) begin
            exp_q.delete();
        end else begin
            if (bus.instr_valid && bus.instr_ready) begin
                pop_cyc.push_back(cyc);
                check("instr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
                    check("instr_data", 32'(bus.instr_data), 32'(e.data));
                end
            end
            if (bus.pc_valid && bus.pc_ready)
                exp_q.push_back('{bus.pc_in, {8'hA5, bus.pc_in}});
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    // Present a PC and hold it until accepted; returns just after the accepting edge
    task automatic send_pc(input logic [7:0] pc, output int acc_c);
        int n;
        n = 0;
        bus.pc_valid = 1'b1;
        bus.pc_in    = pc;
        sample();
        while (!bus.pc_ready && n < 40) begin
            sample();
            n++;
        end
        if (n >= 40) check("pc_accept_timeout", 32'(n), 32'd0);
        acc_c = cyc;
        step();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        sample();
        while ((exp_q.size() != 0 || bus.instr_valid || bus.occupancy != 0) && n < 60) begin
            sample();
            n++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_occupancy", 32'(bus.occupancy), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int a0;
        int dummy;

        reset             = 1'b1;
        bus.pc_valid      = 1'b1;
        bus.pc_in         = 8'h77;
        bus.mem_req_ready = 1'b1;
        bus.flush         = 1'b0;
        bus.instr_ready   = 1'b0;

        // 1: reset holds all handshakes low even with pc_valid up
        step();
        sample();
        check("rst_pc_ready", 32'(bus.pc_ready), 32'd0);
        check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        step();
        reset        = 1'b0;
        bus.pc_valid = 1'b0;
        step();

        // 2: streaming at one per cycle, latency 1
        lat = 1;
        bus.instr_ready = 1'b1;
        pop_cyc.delete();
        send_pc(8'h00, a0);
        for (int i = 1; i < 6; i++) send_pc(8'(i), dummy);
        bus.pc_valid = 1'b0;
        wait_idle();
        check("stream_pops", 32'(pop_cyc.size()), 32'd6);
        for (int i = 0; i < 6 && i < pop_cyc.size(); i++)
            check("stream_pop_cycle", 32'(pop_cyc[i]), 32'(a0 + 2 + i));

        // 3: fill to DEPTH with decode stalled, then release
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_pc(8'h10 + 8'(i), dummy);
        bus.pc_in = 8'h14;
        step(); step(); step();
        sample();
        check("full_occupancy", 32'(bus.occupancy), 32'd4);
        check("full_pc_ready", 32'(bus.pc_ready), 32'd0);
        check("full_instr_valid", 32'(bus.instr_valid), 32'd1);
        check("full_head_pc", 32'(bus.instr_pc), 32'h10);
        step();
        bus.instr_ready = 1'b1;
        sample();
        check("full_no_bypass", 32'(bus.pc_ready), 32'd0);
        step();
        sample();
        check("credit_after_pop", 32'(bus.pc_ready), 32'd1);
        step();
        for (int i = 5; i < 8; i++) send_pc(8'h10 + 8'(i), dummy);
        bus.pc_valid = 1'b0;
        wait_idle();

        // 4: latency 3, flush with three in flight, then refetch
        lat = 3;
        send_pc(8'h20, dummy);
        send_pc(8'h21, dummy);
        send_pc(8'h22, dummy);
        bus.pc_valid = 1'b0;
        bus.flush    = 1'b1;
        sample();
        check("flush_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("flush_pc_ready", 32'(bus.pc_ready), 32'd0);
        step();
        bus.flush = 1'b0;
        sample();
        check("postflush_occupancy", 32'(bus.occupancy), 32'd0);
        check("postflush_discard", 32'(dut.discard_cnt), 32'd2);
        step();
        send_pc(8'h40, dummy);
        bus.pc_valid = 1'b0;
        sample();
        check("refetch_occupancy", 32'(bus.occupancy), 32'd1);
        check("refetch_not_ready", 32'(bus.instr_valid), 32'd0);
        step();
        wait_idle();

        // 5: flush colliding with a response and a would-be pop
        mem_auto        = 1'b0;
        bus.instr_ready = 1'b0;
        send_pc(8'h30, dummy);
        bus.pc_valid = 1'b0;
        man_v = 1'b1; man_d = 16'hA530;
        step();
        man_v = 1'b0;
        send_pc(8'h31, dummy);
        send_pc(8'h32, dummy);
        bus.pc_valid    = 1'b0;
        bus.flush       = 1'b1;
        bus.instr_ready = 1'b1;
        man_v = 1'b1; man_d = 16'hA531;
        sample();
        check("collide_instr_valid", 32'(bus.instr_valid), 32'd0);
        step();
        bus.flush = 1'b0;
        man_v     = 1'b0;
        sample();
        check("collide_occupancy", 32'(bus.occupancy), 32'd0);
        check("collide_discard", 32'(dut.discard_cnt), 32'd1);
        check("collide_instr_valid_after", 32'(bus.instr_valid), 32'd0);
        step();
        send_pc(8'h33, dummy);
        bus.pc_valid = 1'b0;
        man_v = 1'b1; man_d = 16'hA532;
        step();
        man_d = 16'hA533;
        step();
        man_v = 1'b0;
        wait_idle();

        // 6: reset with queued and outstanding entries, then stray responses
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_pc(8'h60 + 8'(i), dummy);
        bus.pc_valid = 1'b0;
        man_v = 1'b1; man_d = 16'hA560;
        step();
        man_d = 16'hA561;
        step();
        man_v = 1'b0;
        sample();
        check("prereset_occupancy", 32'(bus.occupancy), 32'd4);
        step();
        reset = 1'b1;
        step();
        sample();
        check("midreset_occupancy", 32'(bus.occupancy), 32'd0);
        check("midreset_pc_ready", 32'(bus.pc_ready), 32'd0);
        step();
        reset = 1'b0;
        man_v = 1'b1; man_d = 16'hA562;
        step();
        man_d = 16'hA563;
        step();
        man_v = 1'b0;
        sample();
        check("stray_occupancy", 32'(bus.occupancy), 32'd0);
        check("stray_instr_valid", 32'(bus.instr_valid), 32'd0);
        step();
        mem_auto        = 1'b1;
        lat             = 1;
        bus.instr_ready = 1'b1;
        pop_cyc.delete();
        send_pc(8'h50, dummy);
        bus.pc_valid = 1'b0;
        wait_idle();
        check("after_reset_pops", 32'(pop_cyc.size()), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
